// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the multi-cycle div/rem sequencer.
package div_sequencer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // ALU control codes handled by this block
  localparam logic [3:0] ALU_DIV = 4'd4;
  localparam logic [3:0] ALU_REM = 4'd6;

  // Special-case operand/result constants
  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division step: shift {rem, quot} left, trial-subtract the
// divisor magnitude, keep or restore, and shift in the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH:0]   i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quot
);

  // One guard bit above the 33-bit remainder gives the trial-subtract sign
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  assign w_shift = {i_rem, i_quot[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_dvs};

  // Keep the difference when non-negative, otherwise restore the shifted remainder
  always_comb begin
    if (!w_diff[WIDTH+1]) begin
      o_rem  = w_diff[WIDTH:0];
      o_quot = {i_quot[WIDTH-2:0], 1'b1};
    end else begin
      o_rem  = w_shift[WIDTH:0];
      o_quot = {i_quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M div/rem sequencer: 32-step restoring division on operand
// magnitudes with sign correction, stalling the core until the result is ready.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  import div_sequencer_pkg::*;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic             r_op_rem;
  logic             r_sgn_dvd;
  logic             r_sgn_dvs;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH:0]   r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_special_res;
  logic [WIDTH:0]   w_next_rem;
  logic [WIDTH-1:0] w_next_quot;
  logic [WIDTH-1:0] w_final_res;

  // Two's-complement negate when requested; used for magnitudes and sign fix-up
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // |INT_MIN| comes out as 0x80000000, which is exact when read unsigned
  assign w_dvd_abs = apply_sign(dividend, dividend[WIDTH-1]);
  assign w_dvs_abs = apply_sign(divisor, divisor[WIDTH-1]);

  assign w_div_zero = (divisor == '0);
  assign w_ovf      = (dividend == INT_MIN) && (divisor == DIV_BY_ZERO_Q);

  // Results for operands that never enter CALC
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = r_op_rem_sel(op_rem, dividend, DIV_BY_ZERO_Q);
    end else begin
      w_special_res = r_op_rem_sel(op_rem, '0, INT_MIN);
    end
  end

  function automatic logic [WIDTH-1:0] r_op_rem_sel(input logic sel_rem,
                                                    input logic [WIDTH-1:0] rem_v,
                                                    input logic [WIDTH-1:0] quot_v);
    return sel_rem ? rem_v : quot_v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quot (r_quot),
    .i_dvs  (r_dvs),
    .o_rem  (w_next_rem),
    .o_quot (w_next_quot)
  );

  // Quotient sign follows sign mismatch; remainder follows the dividend
  assign w_final_res = r_op_rem ? apply_sign(w_next_rem[WIDTH-1:0], r_sgn_dvd)
                                : apply_sign(w_next_quot, r_sgn_dvd ^ r_sgn_dvs);

  // Sequencer FSM: accept in IDLE, iterate in CALC, present result in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          r_rem   <= '0;
          r_cnt   <= '0;
          if (start) begin
            r_op_rem  <= op_rem;
            r_sgn_dvd <= dividend[WIDTH-1];
            r_sgn_dvs <= divisor[WIDTH-1];
            r_quot    <= w_dvd_abs;
            r_dvs     <= {1'b0, w_dvs_abs};
            if (w_div_zero || w_ovf) begin
              r_result <= w_special_res;
              r_valid  <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem  <= w_next_rem;
          r_quot <= w_next_quot;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_result <= w_final_res;
            r_valid  <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // start only stalls in IDLE; reset masks it so the core is never held in reset
  assign stall        = !reset && (((r_state == IDLE) && start) || (r_state == CALC));
  assign busy         = (r_state == CALC);
  assign result_valid = r_valid;
  assign result       = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: driver pushes expected results from a
// plain-arithmetic reference; a negedge monitor pops and compares each strobe.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_rem;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_rem       (op_rem),
    .dividend     (dividend),
    .divisor      (divisor),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  typedef struct {
    logic [31:0] res;
    int          start_cyc;
    int          lat;
    int          id;
  } exp_t;

  exp_t scb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_ops  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics with native signed arithmetic
  function automatic logic [31:0] ref_div(input bit is_rem, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sd;
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
    sa = a;
    sd = b;
    return is_rem ? 32'(sa % sd) : 32'(sa / sd);
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got strobe with result %h expected no strobe", result);
      end else begin
        mon_e = scb.pop_front();
        check($sformatf("op%0d_result", mon_e.id), result, mon_e.res);
        check($sformatf("op%0d_latency", mon_e.id), 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
      end
    end
  end

  // Issue one op at posedge+1; returns at posedge+1 of the IDLE cycle after DONE
  // with start still high so the caller may chain or drop it.
  task automatic do_op(input bit r, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   special;
    bit   got;
    bit   stall_ok;
    int   busy_cnt;
    special     = (b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    e.res       = ref_div(r, a, b);
    e.start_cyc = cyc;
    e.lat       = special ? 1 : 33;
    e.id        = n_ops;
    n_ops++;
    scb.push_back(e);
    start    = 1'b1;
    op_rem   = r;
    dividend = a;
    divisor  = b;
    got      = 1'b0;
    stall_ok = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        got = 1'b1;
        check($sformatf("op%0d_stall_done", e.id), 32'(stall), 32'd0);
      end else begin
        if (stall !== 1'b1) stall_ok = 1'b0;
        if (busy === 1'b1) busy_cnt++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL op%0d_timeout: got no result_valid in 40 cycles expected one", e.id);
    end
    check($sformatf("op%0d_stall_held", e.id), 32'(stall_ok), 32'd1);
    check($sformatf("op%0d_busy_cycles", e.id), 32'(busy_cnt), special ? 32'd0 : 32'd32);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    reset    = 1'b1;
    start    = 1'b1;
    op_rem   = 1'b0;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_result", result, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_stall", 32'(stall), 32'd0);

    // Directed cases, gap between each
    do_op(1'b0, 32'd100, 32'd7);              start = 1'b0; @(posedge clk); #1;
    do_op(1'b1, -32'sd100, 32'd7);            start = 1'b0; @(posedge clk); #1;
    do_op(1'b0, -32'sd100, 32'd7);            start = 1'b0; @(posedge clk); #1;
    do_op(1'b0, 32'd100, -32'sd7);            start = 1'b0; @(posedge clk); #1;
    do_op(1'b0, 32'd5, 32'd0);                start = 1'b0; @(posedge clk); #1;
    do_op(1'b1, 32'd5, 32'd0);                start = 1'b0; @(posedge clk); #1;
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF); start = 1'b0; @(posedge clk); #1;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); start = 1'b0; @(posedge clk); #1;

    // Abort in CALC: start at cycle 0, reset during cycle 10, cycle 11 idle
    start    = 1'b1;
    op_rem   = 1'b0;
    dividend = 32'd12345;
    divisor  = 32'd17;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    @(posedge clk);
    #1;

    // Recovery op, then start held through DONE straight into a rem
    do_op(1'b0, 32'd9, 32'd3);
    do_op(1'b1, 32'd17, 32'd5);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Randomised ops mixing signs, small/large divisors and special cases
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(1, 20));
        1: rb = -32'($urandom_range(1, 20));
        2: rb = $urandom;
        3: rb = 32'd0;
        default: begin
          rb = 32'hFFFF_FFFF;
          if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
        end
      endcase
      do_op(1'($urandom_range(0, 1)), ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;

    for (int k = 0; k < 50 && scb.size() != 0; k++) @(posedge clk);
    check("scoreboard_drained", 32'(scb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the RV32M `div`/`rem` operations (ALU control codes 4 and 6) in the single-cycle core. The control unit decodes the instruction; this block runs a 32-step restoring division over the two register operands and stalls the PC and the register-file write until the result is ready. Every other ALU operation bypasses this block.

## Interface
- `WIDTH`, 32: operand and result width. The sign rules below assume two's complement at this width.

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  decoded instruction is `div` or `rem`; level, held while the instruction sits in decode
- `op_rem`  in  1  1 = `rem` (ALU code 6), 0 = `div` (ALU code 4); sampled with `start`
- `dividend`  in  WIDTH  rs1 value, signed; sampled with `start`
- `divisor`  in  WIDTH  rs2 value, signed; sampled with `start`
- `stall`  out  1  holds the PC and suppresses RegWrite
- `busy`  out  1  high in CALC
- `result_valid`  out  1  one-cycle strobe; the core writes `result` to rd in this cycle
- `result`  out  WIDTH  quotient or remainder

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE:**
  - `stall = start` (combinational).
  - On `start`: register `op_rem`, the sign of the dividend, the sign of the divisor, |dividend| and |divisor|.
  - Clear the 33-bit partial remainder and the 6-bit step counter.
  - Next state is DONE if the operands are a special case, otherwise CALC.
- **CALC:**
  - `stall = 1`, `busy = 1`.
  - Each cycle performs one restoring step. Shift {rem, quot} left by 1, bringing in the next dividend MSB. Trial-subtract |divisor| from the 33-bit remainder. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - The counter increments every cycle. After step 31 (counter = 31), go to DONE.
- **DONE:**
  - `stall = 0`, `result_valid = 1`.
  - `result` is the registered, sign-corrected value:
    - quotient is negated if the dividend sign differs from the divisor sign;
    - remainder takes the dividend's sign.
  - Always go to IDLE next. `start` is ignored in DONE, because the same instruction is still in decode.
- **Special cases** (resolved in IDLE, no CALC):
  - divisor = 0: quotient = all ones (0xFFFFFFFF), remainder = dividend.
  - dividend = 0x80000000 and divisor = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Division truncates toward zero. The magnitude of 0x80000000 is represented in 33 bits, so no overflow occurs in CALC.
- **Reset:** state = IDLE. `stall`, `busy`, `result_valid` = 0 (`stall` is 0 because `start` is ignored under reset). `result` = 0, counter = 0.
- **Reset mid-operation** (CALC or DONE): abort, return to IDLE next cycle, and produce no `result_valid`.

## Timing
- **Normal operation:**
  - cycle 0: IDLE with `start` → `stall = 1`;
  - cycles 1–32: CALC;
  - cycle 33: DONE → `result_valid = 1`, `stall = 0`, PC advances at the end of cycle 33.
  - Total instruction occupancy is 34 cycles.
- **Special case:** cycle 0 stall, cycle 1 DONE. Occupancy is 2 cycles.
- **Back-to-back div/rem:** the next instruction's `start` is accepted in the IDLE cycle that follows DONE. There are no bubbles other than that IDLE accept cycle.
- **Glitch-free outputs:** `result` and `result_valid` are registered. `stall` is combinational from `start` and the state only.

## Structure
- **Shared package:**
  - state enum (IDLE/CALC/DONE);
  - ALU control constants `ALU_DIV = 4`, `ALU_REM = 6`;
  - special-case constants `DIV_BY_ZERO_Q` (all ones) and `INT_MIN` (0x80000000).
- **Sub-module `div_step`:** one natural combinational sub-module.
  - Inputs: 33-bit remainder, quotient, |divisor|.
  - Outputs: next remainder, next quotient.
  - The FSM instantiates it once and reuses it every CALC cycle.

## Test plan
- `div` 100 / 7: `stall` high for cycles 0–32; `result_valid` at cycle 33 with `result` = 14, for exactly one cycle.
- `rem` −100 % 7 → 0xFFFFFFFE (−2); `div` −100 / 7 → 0xFFFFFFF2 (−14); `div` 100 / −7 → 0xFFFFFFF2.
- `div` 5 / 0 → 0xFFFFFFFF; `rem` 5 % 0 → 5; both with `result_valid` at cycle 1 and no `busy`.
- 0x80000000 / 0xFFFFFFFF: `div` → 0x80000000, `rem` → 0, both at cycle 1.
- `reset` asserted at cycle 10 of CALC: cycle 11 is IDLE with `stall`, `busy`, `result_valid` = 0; a later `div` 9 / 3 → 3 completes normally.
- `start` held through DONE, then a new `rem` 17 % 5 starting in the IDLE cycle after DONE: exactly one `result_valid` for the first op, then 2 after a further 34 cycles.
